// File: rtl/draw_pkg.sv
// Shared types and defaults for the playfield background stage and its flash FSM.
package draw_pkg;

    typedef logic [11:0] rgb_t;

    localparam int DEF_HOR_PIX   = 1024;
    localparam int DEF_VER_PIX   = 768;
    localparam int DEF_GRID_LOG2 = 4;

    localparam rgb_t DEF_BORDER_COLOR = 12'h740;
    localparam rgb_t DEF_FLASH_COLOR  = 12'hF00;
    localparam rgb_t DEF_BG_COLOR     = 12'hDA5;
    localparam rgb_t DEF_BG_ALT_COLOR = 12'hC94;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_t;

    // Halves each 4-bit channel; used for the darker grid-line shade.
    function automatic rgb_t half_rgb(input rgb_t c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage

// File: rtl/flash_fsm.sv
// Border flash sequencer: alternates ON/OFF phases of FLASH_PERIOD frames, FLASH_COUNT phases total.
module flash_fsm
    import draw_pkg::*;
#(
    parameter int FLASH_PERIOD = 8,
    parameter int FLASH_COUNT  = 6
) (
    input  logic pclk,
    input  logic rst,
    input  logic frame_tick,
    input  logic flash_req,
    output logic flash_on,
    output logic flash_busy
);

    localparam int FW = $clog2(FLASH_PERIOD + 1);
    localparam int PW = $clog2(FLASH_COUNT + 1);

    flash_state_t  state, state_nxt;
    logic [FW-1:0] frame_cnt, frame_nxt;
    logic [PW-1:0] phase, phase_nxt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            phase     <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_nxt;
            phase     <= phase_nxt;
        end
    end

    // A request always wins over a coincident frame tick.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        phase_nxt = phase;
        if (flash_req) begin
            state_nxt = FLASH_ON;
            frame_nxt = '0;
            phase_nxt = PW'(1);
        end else if (frame_tick && state != IDLE) begin
            if (frame_cnt == FW'(FLASH_PERIOD - 1)) begin
                frame_nxt = '0;
                if (phase == PW'(FLASH_COUNT)) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                    phase_nxt = phase + PW'(1);
                end
            end else begin
                frame_nxt = frame_cnt + FW'(1);
            end
        end
    end

    assign flash_on   = (state == FLASH_ON);
    assign flash_busy = (state != IDLE);

endmodule

// File: rtl/draw_playfield.sv
// Playfield background: blanking, border ring (with flash), solid/checker interior; 2-cycle latency.
// Optional grid-line overlay on the interior: define DRAW_PLAYFIELD_GRID_LINES_EN.
module draw_playfield
    import draw_pkg::*;
#(
    parameter int   HOR_PIX      = DEF_HOR_PIX,
    parameter int   VER_PIX      = DEF_VER_PIX,
    parameter int   GRID_LOG2    = DEF_GRID_LOG2,
    parameter int   FRAME_X_SIZE = 40,
    parameter int   FRAME_Y_SIZE = 20,
    parameter int   FRAME_WIDTH  = 1,
    parameter rgb_t BORDER_COLOR = DEF_BORDER_COLOR,
    parameter rgb_t FLASH_COLOR  = DEF_FLASH_COLOR,
    parameter rgb_t BG_COLOR     = DEF_BG_COLOR,
    parameter rgb_t BG_ALT_COLOR = DEF_BG_ALT_COLOR,
    parameter int   FLASH_PERIOD = 8,
    parameter int   FLASH_COUNT  = 6
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        checker_en,
    input  logic        flash_req,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [6:0]  grid_x_out,
    output logic [5:0]  grid_y_out,
    output logic        flash_busy
);

    localparam int GRID   = 1 << GRID_LOG2;
    localparam int X_OUT  = (HOR_PIX - FRAME_X_SIZE * GRID) / 2;
    localparam int Y_OUT  = (VER_PIX - FRAME_Y_SIZE * GRID) / 2;
    localparam int X_END  = X_OUT + FRAME_X_SIZE * GRID;
    localparam int Y_END  = Y_OUT + FRAME_Y_SIZE * GRID;
    localparam int BW     = FRAME_WIDTH * GRID;

    localparam logic [10:0] XO_L = 11'(X_OUT);
    localparam logic [10:0] XO_H = 11'(X_END);
    localparam logic [10:0] YO_L = 11'(Y_OUT);
    localparam logic [10:0] YO_H = 11'(Y_END);
    localparam logic [10:0] XI_L = 11'(X_OUT + BW);
    localparam logic [10:0] XI_H = 11'(X_END - BW);
    localparam logic [10:0] YI_L = 11'(Y_OUT + BW);
    localparam logic [10:0] YI_H = 11'(Y_END - BW);

    logic vblnk_d, frame_tick, flash_on;
    logic in_outer, in_inner;

    assign frame_tick = vblnk_in & ~vblnk_d;

    assign in_outer = (hcount_in >= XO_L) && (hcount_in < XO_H) &&
                      (vcount_in >= YO_L) && (vcount_in < YO_H);
    assign in_inner = (hcount_in >= XI_L) && (hcount_in < XI_H) &&
                      (vcount_in >= YI_L) && (vcount_in < YI_H);

    flash_fsm #(
        .FLASH_PERIOD (FLASH_PERIOD),
        .FLASH_COUNT  (FLASH_COUNT)
    ) u_flash (
        .pclk       (pclk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .flash_req  (flash_req),
        .flash_on   (flash_on),
        .flash_busy (flash_busy)
    );

    // Stage 1: geometry classification and timing capture.
    logic [10:0] s1_hcount, s1_vcount;
    logic        s1_hsync, s1_hblnk, s1_vsync, s1_vblnk;
    logic [6:0]  s1_gx;
    logic [5:0]  s1_gy;
    logic        s1_blank, s1_border, s1_inner, s1_parity, s1_chk;
`ifdef DRAW_PLAYFIELD_GRID_LINES_EN
    localparam rgb_t GRID_LINE_COLOR = half_rgb(BG_COLOR);
    logic s1_gline;

    always_ff @(posedge pclk) begin
        if (rst) s1_gline <= 1'b0;
        else     s1_gline <= (hcount_in[GRID_LOG2-1:0] == '0) ||
                             (vcount_in[GRID_LOG2-1:0] == '0);
    end
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_d   <= 1'b0;
            s1_hcount <= '0;
            s1_vcount <= '0;
            s1_hsync  <= 1'b0;
            s1_hblnk  <= 1'b0;
            s1_vsync  <= 1'b0;
            s1_vblnk  <= 1'b0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            s1_blank  <= 1'b0;
            s1_border <= 1'b0;
            s1_inner  <= 1'b0;
            s1_parity <= 1'b0;
            s1_chk    <= 1'b0;
        end else begin
            vblnk_d   <= vblnk_in;
            s1_hcount <= hcount_in;
            s1_vcount <= vcount_in;
            s1_hsync  <= hsync_in;
            s1_hblnk  <= hblnk_in;
            s1_vsync  <= vsync_in;
            s1_vblnk  <= vblnk_in;
            s1_gx     <= 7'(hcount_in >> GRID_LOG2);
            s1_gy     <= 6'(vcount_in >> GRID_LOG2);
            s1_blank  <= hblnk_in | vblnk_in;
            s1_border <= in_outer & ~in_inner;
            s1_inner  <= in_inner;
            s1_parity <= hcount_in[GRID_LOG2] ^ vcount_in[GRID_LOG2];
            s1_chk    <= checker_en;
        end
    end

    // Stage 2: colour priority blank > border > interior > outside.
    rgb_t rgb_nxt;

    always_comb begin
        rgb_nxt = BG_COLOR;
        if (s1_blank) begin
            rgb_nxt = 12'h000;
        end else if (s1_border) begin
            rgb_nxt = flash_on ? FLASH_COLOR : BORDER_COLOR;
        end else if (s1_inner) begin
            rgb_nxt = (s1_chk && s1_parity) ? BG_ALT_COLOR : BG_COLOR;
`ifdef DRAW_PLAYFIELD_GRID_LINES_EN
            if (s1_gline) rgb_nxt = GRID_LINE_COLOR;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            grid_x_out <= '0;
            grid_y_out <= '0;
        end else begin
            hcount_out <= s1_hcount;
            vcount_out <= s1_vcount;
            hsync_out  <= s1_hsync;
            hblnk_out  <= s1_hblnk;
            vsync_out  <= s1_vsync;
            vblnk_out  <= s1_vblnk;
            rgb_out    <= rgb_nxt;
            grid_x_out <= s1_gx;
            grid_y_out <= s1_gy;
        end
    end

endmodule

// File: tb/tb_draw_playfield.sv
// Bench for draw_playfield: per-cycle compare against a frame-level model plus directed spot checks.
module tb_draw_playfield;

    localparam int GRID = 16;
    localparam int XO   = (1024 - 40 * GRID) / 2;
    localparam int YO   = (768 - 20 * GRID) / 2;
    localparam int FP   = 8;
    localparam int FC   = 6;

`ifdef DRAW_PLAYFIELD_GRID_LINES_EN
    localparam bit GL_EN = 1'b1;
`else
    localparam bit GL_EN = 1'b0;
`endif
    // Expected for inner pixels sitting on a grid line (depends on build option).
    localparam logic [11:0] GLN = GL_EN ? 12'h652 : 12'hDA5;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 0, hblnk_in = 0, vsync_in = 0, vblnk_in = 0;
    logic        checker_en = 0, flash_req = 0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [6:0]  grid_x_out;
    logic [5:0]  grid_y_out;
    logic        flash_busy;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    draw_playfield dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .checker_en(checker_en), .flash_req(flash_req),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .grid_x_out(grid_x_out), .grid_y_out(grid_y_out),
        .flash_busy(flash_busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Colour straight from the geometric description of the playfield.
    function automatic logic [11:0] model_rgb(input int h, input int v, input bit blank,
                                              input bit chk_en, input bit on);
        bit outer, inner;
        if (blank) return 12'h000;
        outer = (h >= XO) && (h < XO + 40 * GRID) && (v >= YO) && (v < YO + 20 * GRID);
        inner = (h >= XO + GRID) && (h < XO + 39 * GRID) && (v >= YO + GRID) && (v < YO + 19 * GRID);
        if (outer && !inner) return on ? 12'hF00 : 12'h740;
        if (inner) begin
            if (GL_EN && ((h % GRID) == 0 || (v % GRID) == 0)) return 12'h652;
            if (chk_en && (((h / GRID) + (v / GRID)) % 2 == 1)) return 12'hC94;
            return 12'hDA5;
        end
        return 12'hDA5;
    endfunction

    typedef struct {
        bit          valid;
        logic [10:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb;
        logic [6:0]  gx;
        logic [5:0]  gy;
    } exp_t;

    // Compare process: outputs after edge k vs model, then model steps edge k+1.
    initial begin
        exp_t d1, d2, zero_e;
        bit   m_ok, m_busy, vb_prev, tick, on;
        int   n_tick;
        zero_e = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 7'd0, 6'd0};
        d1 = zero_e; d1.valid = 0;
        d2 = d1;
        m_ok = 0; m_busy = 0; vb_prev = 0; n_tick = 0;
        forever begin
            @(negedge pclk);
            if (d2.valid) begin
                chk("hcount_out", 32'(hcount_out), 32'(d2.h));
                chk("vcount_out", 32'(vcount_out), 32'(d2.v));
                chk("sync_blank_out", {hsync_out, hblnk_out, vsync_out, vblnk_out},
                    {d2.hs, d2.hb, d2.vs, d2.vb});
                chk("rgb_out", 32'(rgb_out), 32'(d2.rgb));
                chk("grid_x_out", 32'(grid_x_out), 32'(d2.gx));
                chk("grid_y_out", 32'(grid_y_out), 32'(d2.gy));
            end
            if (m_ok) chk("flash_busy", 32'(flash_busy), 32'(m_busy));
            if (rst) begin
                d1 = zero_e; d1.valid = 0;
                d2 = zero_e;
                m_ok = 1; m_busy = 0; vb_prev = 0; n_tick = 0;
            end else begin
                tick = vblnk_in && !vb_prev;
                vb_prev = vblnk_in;
                if (flash_req) begin
                    m_busy = 1; n_tick = 0;
                end else if (m_busy && tick) begin
                    n_tick++;
                    if (n_tick == FP * FC) m_busy = 0;
                end
                on = m_busy && ((n_tick / FP) % 2 == 0);
                d2 = d1;
                d1.valid = 1;
                d1.h = hcount_in; d1.v = vcount_in;
                d1.hs = hsync_in; d1.hb = hblnk_in; d1.vs = vsync_in; d1.vb = vblnk_in;
                d1.rgb = model_rgb(int'(hcount_in), int'(vcount_in), hblnk_in | vblnk_in,
                                   checker_en, on);
                d1.gx = 7'(int'(hcount_in) / GRID);
                d1.gy = 6'(int'(vcount_in) / GRID);
            end
        end
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input string name, input int h, input int v, input bit ce,
                       input bit hb, input logic [11:0] exp);
        hcount_in = 11'(h); vcount_in = 11'(v); checker_en = ce; hblnk_in = hb;
        cyc(); cyc();
        chk(name, 32'(rgb_out), 32'(exp));
    endtask

    task automatic frame_tick();
        vblnk_in = 1; cyc(); cyc();
        vblnk_in = 0; cyc(); cyc();
    endtask

    task automatic pulse_req();
        flash_req = 1; cyc();
        flash_req = 0; cyc(); cyc();
    endtask

    initial begin
        int hs[8];
        logic [11:0] he[8];
        int vs[4];
        logic [11:0] ve[4];
        hs = '{191, 192, 207, 208, 815, 816, 831, 832};
        he = '{12'hDA5, 12'h740, 12'h740, GLN, 12'hDA5, 12'h740, 12'h740, 12'hDA5};
        vs = '{239, 240, 527, 528};
        ve = '{12'h740, GLN, GLN, 12'h740};

        // Reset held with busy inputs: everything must stay cleared.
        #1;
        hcount_in = 11'd200; vcount_in = 11'd300;
        hsync_in = 1; vsync_in = 1; checker_en = 1;
        repeat (4) cyc();
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_counts", {hcount_out, vcount_out}, 32'h0);
        chk("rst_grid", {grid_x_out, grid_y_out}, 32'h0);
        chk("rst_strobes", {hsync_out, hblnk_out, vsync_out, vblnk_out, flash_busy}, 32'h0);
        rst = 0; hsync_in = 0; vsync_in = 0; checker_en = 0;
        cyc();

        pix("first_border", 200, 300, 0, 0, 12'h740);
        chk("first_grid_x", 32'(grid_x_out), 32'd12);
        chk("first_grid_y", 32'(grid_y_out), 32'd18);
        chk("first_hcount", 32'(hcount_out), 32'd200);

        for (int i = 0; i < 8; i++) pix($sformatf("hsweep_%0d", hs[i]), hs[i], 300, 0, 0, he[i]);
        for (int i = 0; i < 4; i++) pix($sformatf("vsweep_%0d", vs[i]), 400, vs[i], 0, 0, ve[i]);

        pix("checker_par0", 208, 240, 1, 0, GLN);
        pix("checker_par1", 224, 240, 1, 0, GL_EN ? 12'h652 : 12'hC94);
        pix("checker_hblnk", 224, 240, 1, 1, 12'h000);
        pix("grid_line", 224, 250, 0, 0, GLN);

        // Full flash sequence on a border pixel.
        hcount_in = 11'd200; vcount_in = 11'd300; checker_en = 0; hblnk_in = 0;
        pulse_req();
        chk("flash_start_rgb", 32'(rgb_out), 32'hF00);
        chk("flash_start_busy", 32'(flash_busy), 32'h1);
        for (int n = 1; n <= FP * FC; n++) begin
            frame_tick();
            if (n == 7 || n == 8 || n == 16 || n == 47 || n == 48) begin
                chk($sformatf("flash_rgb_t%0d", n), 32'(rgb_out),
                    ((n / FP) % 2 == 0 && n < FP * FC) ? 32'hF00 : 32'h740);
                chk($sformatf("flash_busy_t%0d", n), 32'(flash_busy), (n < FP * FC) ? 32'h1 : 32'h0);
            end
        end

        // Restart mid-sequence.
        pulse_req();
        for (int n = 1; n <= 20; n++) frame_tick();
        chk("restart_pre_rgb", 32'(rgb_out), 32'hF00);
        pulse_req();
        chk("restart_rgb", 32'(rgb_out), 32'hF00);
        for (int n = 1; n <= 47; n++) frame_tick();
        chk("restart_t47_busy", 32'(flash_busy), 32'h1);
        chk("restart_t47_rgb", 32'(rgb_out), 32'h740);
        frame_tick();
        chk("restart_t48_busy", 32'(flash_busy), 32'h0);

        // Reset aborts a running flash.
        pulse_req();
        for (int n = 1; n <= 5; n++) frame_tick();
        chk("abort_pre_rgb", 32'(rgb_out), 32'hF00);
        rst = 1; cyc(); cyc();
        chk("abort_rst_busy", 32'(flash_busy), 32'h0);
        chk("abort_rst_rgb", 32'(rgb_out), 32'h0);
        rst = 0; cyc(); cyc(); cyc();
        chk("abort_rgb", 32'(rgb_out), 32'h740);
        chk("abort_busy", 32'(flash_busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
